// File: rtl/decode_issue_stage.sv
// RV32I decode/issue stage: operand select, decode, 2-entry skid buffer.
// Optional M-extension decode enabled by defining DECODE_MEXT_EN.
module decode_issue_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 7,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [XLEN-1:0]         rf_rs1_data,
  input  logic [XLEN-1:0]         rf_rs2_data,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic [SEL_W-1:0]        hazard_sel1,
  input  logic [SEL_W-1:0]        hazard_sel2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_op1,
  output logic [XLEN-1:0]         out_op2,
  output logic [XLEN-1:0]         out_store_data,
  output logic [4:0]              out_rd,
  output logic                    out_reg_write,
  output logic [4:0]              out_exec_type,
  output logic                    out_au,
  output logic                    out_mul,
  output logic                    out_lsu,
  output logic                    out_illegal,
  output logic [XLEN-1:0]         out_pc
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] sd;
    logic [4:0]      rd;
    logic [4:0]      exec;
    logic            rw;
    logic            au;
    logic            mul;
    logic            lsu;
    logic            ill;
  } ent_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  logic [XLEN-1:0] src1, src2;
  logic [XLEN-1:0] imm_i, imm_s, imm_u;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  ent_t            dec, m, s;
  logic            m_valid, s_valid;
  logic            acc, drain;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{(XLEN-12){in_instr[31]}},
                  in_instr[31:25], in_instr[11:7]};
  assign imm_u = {{(XLEN-32){in_instr[31]}},
                  in_instr[31:12], 12'b0};

  // Out-of-range selects fall back to the regfile value.
  always_comb begin
    src1 = rf_rs1_data;
    src2 = rf_rs2_data;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (hazard_sel1 == SEL_W'(k + 1))
        src1 = fwd_data[k*XLEN +: XLEN];
      if (hazard_sel2 == SEL_W'(k + 1))
        src2 = fwd_data[k*XLEN +: XLEN];
    end
  end

  always_comb begin
    dec    = '0;
    dec.pc = in_pc;
    dec.rd = in_instr[11:7];
    unique case (opc)
      OP_R: begin
        dec.au  = 1'b1;
        dec.rw  = 1'b1;
        dec.op1 = src1;
        dec.op2 = src2;
        unique case (f7)
          7'b0000000: begin
            unique case (f3)
              3'd0: dec.exec = 5'd0;
              3'd1: dec.exec = 5'd9;
              3'd2: dec.exec = 5'd15;
              3'd3: dec.exec = 5'd17;
              3'd4: dec.exec = 5'd7;
              3'd5: dec.exec = 5'd11;
              3'd6: dec.exec = 5'd5;
              3'd7: dec.exec = 5'd3;
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'd0)      dec.exec = 5'd2;
            else if (f3 == 3'd5) dec.exec = 5'd13;
            else                 dec.ill  = 1'b1;
          end
`ifdef DECODE_MEXT_EN
          7'b0000001: begin
            dec.au   = 1'b0;
            dec.mul  = 1'b1;
            dec.exec = {2'b00, f3};
          end
`endif
          default: dec.ill = 1'b1;
        endcase
      end
      OP_I: begin
        dec.au  = 1'b1;
        dec.rw  = 1'b1;
        dec.op1 = src1;
        dec.op2 = imm_i;
        unique case (f3)
          3'd0: dec.exec = 5'd1;
          3'd2: dec.exec = 5'd16;
          3'd3: dec.exec = 5'd18;
          3'd4: dec.exec = 5'd8;
          3'd6: dec.exec = 5'd6;
          3'd7: dec.exec = 5'd4;
          3'd1: begin
            if (f7 == 7'b0000000) dec.exec = 5'd10;
            else                  dec.ill  = 1'b1;
          end
          3'd5: begin
            if (f7 == 7'b0000000)      dec.exec = 5'd12;
            else if (f7 == 7'b0100000) dec.exec = 5'd14;
            else                       dec.ill  = 1'b1;
          end
        endcase
      end
      OP_LD: begin
        dec.lsu = 1'b1;
        dec.rw  = 1'b1;
        dec.op1 = src1;
        dec.op2 = imm_i;
        unique case (f3)
          3'd0:    dec.exec = 5'd0;
          3'd1:    dec.exec = 5'd1;
          3'd2:    dec.exec = 5'd2;
          3'd4:    dec.exec = 5'd3;
          3'd5:    dec.exec = 5'd4;
          default: dec.ill  = 1'b1;
        endcase
      end
      OP_ST: begin
        dec.lsu = 1'b1;
        dec.op1 = src1;
        dec.op2 = imm_s;
        dec.sd  = src2;
        unique case (f3)
          3'd0:    dec.exec = 5'd5;
          3'd1:    dec.exec = 5'd6;
          3'd2:    dec.exec = 5'd7;
          default: dec.ill  = 1'b1;
        endcase
      end
      OP_LUI: begin
        dec.au   = 1'b1;
        dec.rw   = 1'b1;
        dec.exec = 5'd19;
        dec.op1  = imm_u;
      end
      OP_AUI: begin
        dec.au   = 1'b1;
        dec.rw   = 1'b1;
        dec.exec = 5'd20;
        dec.op1  = in_pc;
        dec.op2  = imm_u;
      end
      default: dec.ill = 1'b1;
    endcase
  end

  assign in_ready = ~s_valid;
  assign acc      = in_valid & ~s_valid;
  assign drain    = m_valid & out_ready;

  // S only fills when M is stalled, so S always holds the younger entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m       <= '0;
      s       <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (s_valid) begin
      if (drain) begin
        m       <= s;
        s_valid <= 1'b0;
      end
    end else if (acc) begin
      if (!m_valid || out_ready) begin
        m       <= dec;
        m_valid <= 1'b1;
      end else begin
        s       <= dec;
        s_valid <= 1'b1;
      end
    end else if (drain) begin
      m_valid <= 1'b0;
    end
  end

  assign out_valid      = m_valid;
  assign out_op1        = m.op1;
  assign out_op2        = m.op2;
  assign out_store_data = m.sd;
  assign out_rd         = m.rd;
  assign out_reg_write  = m.rw;
  assign out_exec_type  = m.exec;
  assign out_au         = m.au;
  assign out_mul        = m.mul;
  assign out_lsu        = m.lsu;
  assign out_illegal    = m.ill;
  assign out_pc         = m.pc;

endmodule
